ntt_stage_sequencer: RTL and testbench
======================================

Name: ntt_stage_sequencer

Overview:
Sequencer directly upstream of the NTT arithmetic unit. It holds an N-entry coefficient buffer and walks the iterative Cooley-Tukey schedule: LOG_N stages of N/2 butterflies each. For every butterfly it first issues a twiddle ROM read (opcode 100), then a butterfly (opcode 011), then writes both registered results back in place. Host loads and reads coefficients through a simple port and pulses start.

Parameters:
LOG_N, 3, log2 of transform size N; the twiddle index must fit the unit's 3-bit ROM address, so LOG_N ≤ 4.
N, 1<<LOG_N, derived coefficient count; must not be overridden.

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  begin transform; sampled only in IDLE
q_in  in  64  modulus; latched on accepted start
mu_in  in  64  Barrett constant; latched on accepted start
ld_en  in  1  coefficient write strobe; ignored unless IDLE
ld_addr  in  LOG_N  write address
ld_data  in  64  write data
rd_addr  in  LOG_N  read address
rd_data  out  64  buffer[rd_addr], combinational
busy  out  1  high in FETCH_TW, BF_ISSUE, WRITEBACK
done  out  1  one-cycle pulse in DONE state
au_opcode  out  3  to arith unit opcode
au_op_a  out  64  to arith unit op_a
au_op_b  out  64  to arith unit op_b
au_op_w  out  64  to arith unit op_w
au_op_q  out  64  to arith unit op_q
au_op_mu  out  64  to arith unit op_mu
au_res_1  in  64  from arith unit res_out_1 (registered, 1-cycle latency)
au_res_2  in  64  from arith unit res_out_2

Behaviour:
- Reset: rst is asynchronous, active-high; clock is clk. On reset, state=IDLE, stage/butterfly counters=0, latched q/mu/w=0, busy=0, done=0. The coefficient buffer is not reset.
- Arith-unit outputs are combinational from state and counters. In IDLE and DONE, au_opcode=000 and all au_op_* = 0. au_op_q and au_op_mu are driven from the latched q/mu in every active state.
- Indexing for stage s (0..LOG_N-1) and butterfly k (0..N/2-1):
  - half = 1<<s; j = k & (half-1)
  - u = ((k>>s)<<(s+1)) | j; v = u + half
  - twiddle index t = j << (LOG_N-1-s), zero-extended to 3 bits.
- FSM:
  - IDLE: on start, latch q_in/mu_in, clear s and k, go to FETCH_TW. Otherwise, if ld_en, write buffer[ld_addr] = ld_data.
  - FETCH_TW: au_opcode=100, au_op_a={61'b0,t}. Next state: BF_ISSUE.
  - BF_ISSUE: latch w = au_res_1, which is the ROM data registered by the unit. Drive au_opcode=011, au_op_a=buf[u], au_op_b=buf[v], au_op_w=au_res_1 (direct, same-cycle value). Next state: WRITEBACK.
  - WRITEBACK: drive au_opcode=000 with zero operands. At the clock edge, buf[u] <= au_res_1 and buf[v] <= au_res_2.
    - If k < N/2-1: k++, go to FETCH_TW.
    - Else if s < LOG_N-1: k=0, s++, go to FETCH_TW.
    - Else go to DONE.
  - DONE: done=1 for one cycle, busy=0, then IDLE.
- Latency: 3 cycles per butterfly; busy is high for 3·(N/2)·LOG_N cycles (36 for N=8). done follows in the next cycle.
- Boundary conditions:
  - start while not IDLE: ignored.
  - ld_en while not IDLE: ignored, buffer unchanged.
  - start and ld_en together in IDLE: start wins, load dropped.
  - rd_addr may be read at any time; mid-run it returns partially transformed data.
  - rst mid-run: immediate return to IDLE, no done pulse, buffer keeps partial data.
- No arithmetic in this block beyond index computation; all modular math is delegated to the arith unit.

Optional Feature:
NTT_SEQ_BITREV_LOAD_EN:
- Defined: IDLE loads write buffer[bitrev(ld_addr)], giving natural-order input for the DIT schedule. rd_addr is unaffected.
- Undefined: load address is used as-is and the host must supply bit-reversed order.

Test Plan:
- Load buffer[i]=i for N=8 (macro off), start with q_in=17, mu_in=0x0F0F -> busy high exactly 36 cycles, then a single done pulse; au_op_q=17 and au_op_mu=0x0F0F throughout.
- Schedule trace, monitoring (s,k) -> (u,v,t):
  - (0,0) -> (0,1,0)
  - (1,1) -> (1,3,2)
  - (2,3) -> (3,7,3)
  - au_opcode sequence per butterfly is 100, 011, 000.
- Stub arith unit returning registered res_1=0xAAAA, res_2=0x5555 on opcode 011 -> after stage-0 butterfly 0, rd_addr=0 gives 0xAAAA and rd_addr=1 gives 0x5555.
- ld_en=1 to addr 2 with 0xDEAD during busy, and start pulsed mid-run -> buffer[2] unchanged by the load, and the run completes with exactly one done.
- rst asserted at cycle 10 of a run -> busy=0, done=0, au_opcode=000 immediately; a new start afterwards runs the full 36 cycles.
- Macro on: load ld_addr=1 (binary 001) with 0x77 -> rd_addr=4 returns 0x77 and rd_addr=1 is unchanged.

Source files
------------

// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer: buffers N coefficients and walks the iterative
// Cooley-Tukey DIT schedule (LOG_N stages x N/2 butterflies). For each
// butterfly it fetches a twiddle from the arith unit ROM, issues the
// butterfly, then writes both registered results back in place.
// Optional: NTT_SEQ_BITREV_LOAD_EN makes host loads land at the bit-reversed
// address so the host can supply natural-order input.
module ntt_stage_sequencer #(
  parameter int LOG_N = 3,
  parameter int N     = 1 << LOG_N
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [63:0]      q_in,
  input  logic [63:0]      mu_in,
  input  logic             ld_en,
  input  logic [LOG_N-1:0] ld_addr,
  input  logic [63:0]      ld_data,
  input  logic [LOG_N-1:0] rd_addr,
  output logic [63:0]      rd_data,
  output logic             busy,
  output logic             done,
  output logic [2:0]       au_opcode,
  output logic [63:0]      au_op_a,
  output logic [63:0]      au_op_b,
  output logic [63:0]      au_op_w,
  output logic [63:0]      au_op_q,
  output logic [63:0]      au_op_mu,
  input  logic [63:0]      au_res_1,
  input  logic [63:0]      au_res_2
);

  localparam int K_W = (LOG_N > 1) ? LOG_N - 1 : 1;
  localparam int S_W = (LOG_N > 2) ? $clog2(LOG_N) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(N / 2 - 1);
  localparam logic [S_W-1:0] S_LAST = S_W'(LOG_N - 1);

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_BF  = 3'b011;
  localparam logic [2:0] OP_TW  = 3'b100;

  typedef enum logic [2:0] {IDLE, FETCH_TW, BF_ISSUE, WRITEBACK, DONE} state_t;

  state_t           state;
  logic [S_W-1:0]   s;
  logic [K_W-1:0]   k;
  logic [63:0]      q_r, mu_r, w_r;
  logic [63:0]      mem [N];
  logic [LOG_N-1:0] u, v, ld_idx;
  logic [2:0]       t;

`ifdef NTT_SEQ_BITREV_LOAD_EN
  function automatic logic [LOG_N-1:0] bitrev(input logic [LOG_N-1:0] a);
    for (int i = 0; i < LOG_N; i++) bitrev[i] = a[LOG_N-1-i];
  endfunction
  assign ld_idx = bitrev(ld_addr);
`else
  // host supplies bit-reversed order itself
  assign ld_idx = ld_addr;
`endif

  assign rd_data = mem[rd_addr];

  // butterfly pair (u,v) and twiddle index t for the current (s,k)
  always_comb begin
    int half, j, ui, vi, ti;
    half = 1 << s;
    j    = int'(k) & (half - 1);
    ui   = ((int'(k) >> s) << (int'(s) + 1)) | j;
    vi   = ui + half;
    ti   = j << (LOG_N - 1 - int'(s));
    u    = ui[LOG_N-1:0];
    v    = vi[LOG_N-1:0];
    t    = ti[2:0];
  end

  // schedule FSM: stage/butterfly counters and latched q/mu/w
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      s     <= '0;
      k     <= '0;
      q_r   <= '0;
      mu_r  <= '0;
      w_r   <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          q_r   <= q_in;
          mu_r  <= mu_in;
          s     <= '0;
          k     <= '0;
          state <= FETCH_TW;
        end
        FETCH_TW: state <= BF_ISSUE;
        BF_ISSUE: begin
          w_r   <= au_res_1;
          state <= WRITEBACK;
        end
        WRITEBACK: begin
          if (k != K_LAST) begin
            k     <= k + 1'b1;
            state <= FETCH_TW;
          end else if (s != S_LAST) begin
            k     <= '0;
            s     <= s + 1'b1;
            state <= FETCH_TW;
          end else begin
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // coefficient buffer: host loads in IDLE (start wins), in-place results on writeback
  always_ff @(posedge clk) begin
    if (state == IDLE && !start && ld_en) begin
      mem[ld_idx] <= ld_data;
    end else if (state == WRITEBACK) begin
      mem[u] <= au_res_1;
      mem[v] <= au_res_2;
    end
  end

  // arith unit drive and status decode
  always_comb begin
    au_opcode = OP_NOP;
    au_op_a   = '0;
    au_op_b   = '0;
    au_op_w   = '0;
    au_op_q   = '0;
    au_op_mu  = '0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      FETCH_TW: begin
        busy      = 1'b1;
        au_opcode = OP_TW;
        au_op_a   = {61'b0, t};
        au_op_q   = q_r;
        au_op_mu  = mu_r;
      end
      BF_ISSUE: begin
        busy      = 1'b1;
        au_opcode = OP_BF;
        au_op_a   = mem[u];
        au_op_b   = mem[v];
        // ROM word arrives this cycle; w_r holds the same value afterwards
        au_op_w   = au_res_1;
        au_op_q   = q_r;
        au_op_mu  = mu_r;
      end
      WRITEBACK: begin
        busy      = 1'b1;
        au_op_q   = q_r;
        au_op_mu  = mu_r;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ntt_stage_sequencer.sv
// Directed bench for ntt_stage_sequencer with a stub arith unit:
// twiddle fetch returns 0x100+index, butterfly returns 0xAAAA / 0x5555.
module tb_ntt_stage_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, ld_en;
  logic [63:0] q_in, mu_in, ld_data, rd_data;
  logic [2:0]  ld_addr, rd_addr, au_opcode;
  logic        busy, done;
  logic [63:0] au_op_a, au_op_b, au_op_w, au_op_q, au_op_mu;
  logic [63:0] res1 = '0, res2 = '0;

  int checks = 0;
  int errors = 0;
  int busy_cnt, done_cnt, c;

  always #5 clk = ~clk;

  ntt_stage_sequencer #(.LOG_N(3)) dut (
    .clk(clk), .rst(rst), .start(start), .q_in(q_in), .mu_in(mu_in),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .rd_addr(rd_addr), .rd_data(rd_data), .busy(busy), .done(done),
    .au_opcode(au_opcode), .au_op_a(au_op_a), .au_op_b(au_op_b),
    .au_op_w(au_op_w), .au_op_q(au_op_q), .au_op_mu(au_op_mu),
    .au_res_1(res1), .au_res_2(res2)
  );

  // stub arith unit, 1-cycle registered results
  always @(posedge clk) begin
    if (au_opcode == 3'b100) res1 <= 64'h100 + au_op_a;
    else if (au_opcode == 3'b011) begin
      res1 <= 64'hAAAA;
      res2 <= 64'h5555;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] rev3(input logic [2:0] a);
    return {a[0], a[1], a[2]};
  endfunction

  // run from an accepted start until done, counting busy/done cycles
  task automatic run_count(output int bc, output int dc);
    int n;
    bc = 0; dc = 0; n = 0;
    while (n < 80 && dc == 0) begin
      if (busy) bc++;
      if (done) dc++;
      @(negedge clk);
      n++;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; q_in = '0; mu_in = '0;
    ld_en = 1'b0; ld_addr = '0; ld_data = '0; rd_addr = '0;
    repeat (2) @(negedge clk);
    chk("rst_busy", {63'b0, busy}, 64'd0);
    chk("rst_done", {63'b0, done}, 64'd0);
    chk("rst_opcode", {61'b0, au_opcode}, 64'd0);
    chk("rst_op_q", au_op_q, 64'd0);
    chk("rst_op_mu", au_op_mu, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // buffer[i] = i
    for (int i = 0; i < 8; i++) begin
      ld_en = 1'b1;
`ifdef NTT_SEQ_BITREV_LOAD_EN
      ld_addr = rev3(3'(i));
`else
      ld_addr = 3'(i);
`endif
      ld_data = 64'(i);
      @(negedge clk);
    end
    ld_en = 1'b0;
    rd_addr = 3'd3; #1 chk("load_rd3", rd_data, 64'd3);
    rd_addr = 3'd6; #1 chk("load_rd6", rd_data, 64'd6);

    // full run with schedule trace; q/mu must stay latched
    start = 1'b1; q_in = 64'd17; mu_in = 64'h0F0F;
    @(negedge clk);
    start = 1'b0; q_in = 64'd99; mu_in = 64'h1234;
    busy_cnt = 0; done_cnt = 0; c = 0;
    while (c < 80 && done_cnt == 0) begin
      if (busy) begin
        busy_cnt++;
        chk("run_op_q", au_op_q, 64'd17);
        chk("run_op_mu", au_op_mu, 64'h0F0F);
      end
      if (done) begin
        done_cnt++;
        chk("done_opcode", {61'b0, au_opcode}, 64'd0);
      end
      case (c)
        0: begin
          chk("s0k0_tw_op", {61'b0, au_opcode}, 64'h4);
          chk("s0k0_t", au_op_a, 64'd0);
        end
        1: begin
          chk("s0k0_bf_op", {61'b0, au_opcode}, 64'h3);
          chk("s0k0_a", au_op_a, 64'd0);
          chk("s0k0_b", au_op_b, 64'd1);
          chk("s0k0_w", au_op_w, 64'h100);
        end
        2: begin
          chk("s0k0_wb_op", {61'b0, au_opcode}, 64'h0);
          chk("s0k0_wb_a", au_op_a, 64'd0);
        end
        3: begin
          rd_addr = 3'd0; #1 chk("s0k0_res_u", rd_data, 64'hAAAA);
          rd_addr = 3'd1; #1 chk("s0k0_res_v", rd_data, 64'h5555);
        end
        15: chk("s1k1_t", au_op_a, 64'd2);
        16: begin
          chk("s1k1_a", au_op_a, 64'h5555);
          chk("s1k1_b", au_op_b, 64'h5555);
          chk("s1k1_w", au_op_w, 64'h102);
        end
        20: begin
          start = 1'b1; ld_en = 1'b1; ld_addr = 3'd2; ld_data = 64'hDEAD;
        end
        21: begin
          start = 1'b0; ld_en = 1'b0;
          rd_addr = 3'd2; #1 chk("busy_load_ignored", rd_data, 64'h5555);
        end
        33: chk("s2k3_t", au_op_a, 64'd3);
        34: begin
          chk("s2k3_bf_op", {61'b0, au_opcode}, 64'h3);
          chk("s2k3_w", au_op_w, 64'h103);
        end
        default: ;
      endcase
      @(negedge clk);
      c++;
    end
    chk("run_busy_cycles", 64'(busy_cnt), 64'd36);
    chk("run_done_count", 64'(done_cnt), 64'd1);
    chk("run_done_cycle", 64'(c), 64'd37);
    chk("after_done", {62'b0, busy, done}, 64'd0);
    rd_addr = 3'd0; #1 chk("final_0", rd_data, 64'hAAAA);
    rd_addr = 3'd3; #1 chk("final_3", rd_data, 64'hAAAA);
    rd_addr = 3'd4; #1 chk("final_4", rd_data, 64'h5555);
    rd_addr = 3'd7; #1 chk("final_7", rd_data, 64'h5555);

    // reset mid-run
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    chk("pre_rst_busy", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", {63'b0, busy}, 64'd0);
    chk("mid_rst_done", {63'b0, done}, 64'd0);
    chk("mid_rst_opcode", {61'b0, au_opcode}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // start with a simultaneous load: start wins, load dropped
    start = 1'b1; ld_en = 1'b1; ld_addr = 3'd5; ld_data = 64'h1234;
    @(negedge clk);
    start = 1'b0; ld_en = 1'b0;
    rd_addr = 3'd5; #1 chk("start_wins_load", rd_data, 64'h5555);
    run_count(busy_cnt, done_cnt);
    chk("rerun_busy_cycles", 64'(busy_cnt), 64'd36);
    chk("rerun_done_count", 64'(done_cnt), 64'd1);

`ifdef NTT_SEQ_BITREV_LOAD_EN
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 64'h77;
    @(negedge clk);
    ld_en = 1'b0;
    rd_addr = 3'd4; #1 chk("bitrev_rd4", rd_data, 64'h77);
    rd_addr = 3'd1; #1 chk("bitrev_rd1", rd_data, 64'hAAAA);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
